// File: rtl/eth_tx_frame_builder_if.sv
// TX frame builder bus: command side, TX RAM write port and driver request.
// The builder is the slave; the sequencer/driver/bench side is the master.
interface eth_tx_frame_builder_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  start;
  logic                  start_ready;
  logic [15:0]           status_in;
  logic [15:0]           seed_in;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;
  logic                  tx_req_n;
  logic [16:0]           tx_bytes;
  logic                  tx_busy;
  logic                  done;
  logic                  timeout_err;
  logic [15:0]           seq_num;

  modport master (
    output start, status_in, seed_in, tx_busy,
    input  start_ready, wr_en, wr_addr, wr_data,
    input  tx_req_n, tx_bytes, done, timeout_err,
    input  seq_num
  );

  modport slave (
    input  start, status_in, seed_in, tx_busy,
    output start_ready, wr_en, wr_addr, wr_data,
    output tx_req_n, tx_bytes, done, timeout_err,
    output seq_num
  );
endinterface

// File: rtl/eth_tx_frame_builder.sv
// Writes a header/payload/XOR-checksum frame into the TX RAM, one word per
// clock, then requests transmission and follows the driver busy handshake.
module eth_tx_frame_builder #(
  parameter int          ADDR_WIDTH     = 9,
  parameter int          PAYLOAD_WORDS  = 16,
  parameter logic [15:0] MAGIC          = 16'hA55A,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst,
  eth_tx_frame_builder_if.slave bus
);

  localparam int N  = PAYLOAD_WORDS + 4;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(N - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    REQ,
    WAIT_DONE
  } state_t;

  state_t                state_q;
  logic [15:0]           status_q;
  logic [15:0]           seed_q;
  logic [15:0]           csum_q;
  logic [15:0]           seq_num_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [15:0]           wr_data_q;
  logic                  tx_req_n_q;
  logic                  done_q;
  logic                  tmo_err_q;
  logic [TW-1:0]         tmo_q;

  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [15:0]           wr_data_d;
  logic [15:0]           csum_d;

  // Word for the next address; the checksum slot folds in the word now on
  // the port so it covers every earlier word.
  always_comb begin
    wr_addr_d = wr_addr_q + 1'b1;
    csum_d    = csum_q ^ wr_data_q;
    wr_data_d = seed_q + 16'(wr_addr_d) - 16'd3;
    unique case (1'b1)
      (wr_addr_d == ADDR_WIDTH'(1)): wr_data_d = seq_num_q;
      (wr_addr_d == ADDR_WIDTH'(2)): wr_data_d = status_q;
      (wr_addr_d == LAST):           wr_data_d = csum_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      status_q   <= '0;
      seed_q     <= '0;
      csum_q     <= '0;
      seq_num_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      tx_req_n_q <= 1'b1;
      done_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            status_q  <= bus.status_in;
            seed_q    <= bus.seed_in;
            csum_q    <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= MAGIC;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (wr_addr_q == LAST) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            tx_req_n_q <= 1'b0;
            tmo_q      <= '0;
            state_q    <= REQ;
          end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            csum_q    <= csum_d;
          end
        end
        REQ: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            tmo_err_q  <= 1'b1;
            tx_req_n_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            done_q     <= 1'b1;
            tx_req_n_q <= 1'b1;
            seq_num_q  <= seq_num_q + 16'd1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.tx_req_n    = tx_req_n_q;
  assign bus.tx_bytes    = 17'(2 * N);
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.seq_num     = seq_num_q;

endmodule
